// File: rtl/pipe_demux1_2.sv
`timescale 1ns/1ps
// pipe_demux1_2: routes each accepted word into one of two independent 2-entry FIFO channels by sel.
// Define PIPE_DEMUX_COUNT_EN to build the saturating per-channel accept counters (cnt0/cnt1 read 0 otherwise).
module pipe_demux1_2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  logic [1:0]       w_full;
  logic [1:0]       w_valid;
  logic [1:0]       w_push;
  logic [1:0]       w_oready;
  logic [WIDTH-1:0] w_head [2];
  logic [15:0]      w_cnt  [2];
  logic             w_accept;

  // in_ready looks only at sel and registered state, so a FULL channel refuses a word even while it pops.
  assign w_oready = {out1_ready, out0_ready};
  assign in_ready = sel ? !w_full[1] : !w_full[0];
  assign w_accept = in_valid && in_ready;
  assign w_push   = {w_accept && sel, w_accept && !sel};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_slot [DEPTH];
    logic             w_pop;

    assign w_pop = (r_state != ST_EMPTY) && w_oready[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_EMPTY;
      end else begin
        r_state <= w_next;
      end
    end

    always_comb begin
      w_next = r_state;
      case (r_state)
        ST_EMPTY: begin
          if (w_push[g]) w_next = ST_ONE;
        end
        ST_ONE: begin
          if (w_push[g] && !w_pop)      w_next = ST_FULL;
          else if (!w_push[g] && w_pop) w_next = ST_EMPTY;
        end
        ST_FULL: begin
          if (w_pop) w_next = ST_ONE;
        end
        default: w_next = ST_EMPTY;
      endcase
    end

    // Slot 0 is always the head; a slot is zeroed when it empties so outN_data reads 0 when EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_push[g]) r_slot[0] <= in_data;
          end
          ST_ONE: begin
            if (w_push[g] && w_pop) r_slot[0] <= in_data;
            else if (w_push[g])     r_slot[1] <= in_data;
            else if (w_pop)         r_slot[0] <= '0;
          end
          ST_FULL: begin
            if (w_pop) begin
              r_slot[0] <= r_slot[1];
              r_slot[1] <= '0;
            end
          end
          default: ;
        endcase
      end
    end

    assign w_head[g]  = r_slot[0];
    assign w_valid[g] = (r_state != ST_EMPTY);
    assign w_full[g]  = (r_state == ST_FULL);

`ifdef PIPE_DEMUX_COUNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= 16'h0000;
      end else if (w_push[g] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end

    assign w_cnt[g] = r_cnt;
`else
    assign w_cnt[g] = 16'h0000;
`endif
  end

  assign out0_data  = w_head[0];
  assign out1_data  = w_head[1];
  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign cnt0       = w_cnt[0];
  assign cnt1       = w_cnt[1];

endmodule

// File: tb/tb_pipe_demux1_2.sv
`timescale 1ns/1ps
// Self-checking bench for pipe_demux1_2: vector table, reset/saturation sequences, random traffic vs queue model.
module tb_pipe_demux1_2;

`ifdef PIPE_DEMUX_COUNT_EN
  localparam bit COUNT_ON = 1'b1;
`else
  localparam bit COUNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] in_data = '0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out0_data, out1_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 1'b0;
  logic        out1_ready = 1'b0;
  logic [15:0] cnt0, cnt1;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          m_c0, m_c1;

  pipe_demux1_2 #(.WIDTH(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [31:0] d;
    logic        s, v, r0, r1;
    logic        rdy;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic [15:0] c0, c1;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic s, input logic v,
                       input logic a, input logic b);
    in_data    = d;
    sel        = s;
    in_valid   = v;
    out0_ready = a;
    out1_ready = b;
  endtask

  function automatic logic [15:0] cexp(input int c);
    return COUNT_ON ? 16'(c) : 16'h0000;
  endfunction

  task automatic do_reset();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    m_c0 = 0;
    m_c1 = 0;
  endtask

  task automatic rcycle();
    logic [31:0] d;
    logic        s, v, a, b, erdy;
    d = $urandom;
    s = 1'($urandom_range(0, 1));
    v = ($urandom_range(0, 3) != 0);
    a = ($urandom_range(0, 4) < 3);
    b = ($urandom_range(0, 4) < 2);
    drive(d, s, v, a, b);
    #1;
    erdy = s ? (q1.size() < 2) : (q0.size() < 2);
    chk("rnd in_ready", {31'b0, in_ready}, {31'b0, erdy});
    @(posedge clk);
    if (q0.size() > 0 && a) void'(q0.pop_front());
    if (q1.size() > 0 && b) void'(q1.pop_front());
    if (v && erdy) begin
      if (s) begin
        q1.push_back(d);
        if (m_c1 < 65535) m_c1++;
      end else begin
        q0.push_back(d);
        if (m_c0 < 65535) m_c0++;
      end
    end
    #1;
    chk("rnd out0_valid", {31'b0, out0_valid}, {31'b0, q0.size() > 0});
    chk("rnd out0_data", out0_data, (q0.size() > 0) ? q0[0] : 32'h0);
    chk("rnd out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() > 0});
    chk("rnd out1_data", out1_data, (q1.size() > 0) ? q1[0] : 32'h0);
    chk("rnd cnt0", {16'b0, cnt0}, {16'b0, cexp(m_c0)});
    chk("rnd cnt1", {16'b0, cnt1}, {16'b0, cexp(m_c1)});
  endtask

  initial begin
    //         d             s     v     r0    r1    rdy   v0    d0            v1    d1            c0  c1
    tbl[0]  = '{32'h00000001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000001, 1'b0, 32'h00000000, 16'd1, 16'd0};
    tbl[1]  = '{32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 16'd1, 16'd1};
    tbl[2]  = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 16'd1, 16'd1};
    tbl[3]  = '{32'hD0BFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0BFFFFF, 1'b0, 32'h00000000, 16'd2, 16'd1};
    tbl[4]  = '{32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0BFFFFF, 1'b0, 32'h00000000, 16'd3, 16'd1};
    tbl[5]  = '{32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hD0BFFFFF, 1'b0, 32'h00000000, 16'd3, 16'd1};
    tbl[6]  = '{32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0BFFFFF, 1'b0, 32'h00000000, 16'd3, 16'd1};
    tbl[7]  = '{32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h00000000, 16'd3, 16'd1};
    tbl[8]  = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 16'd3, 16'd1};
    tbl[9]  = '{32'h0000000A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000000A, 1'b0, 32'h00000000, 16'd4, 16'd1};
    tbl[10] = '{32'h0000000B, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000000B, 1'b0, 32'h00000000, 16'd5, 16'd1};
    tbl[11] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000000B, 1'b0, 32'h00000000, 16'd5, 16'd1};
    tbl[12] = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 16'd5, 16'd1};
    tbl[13] = '{32'h11111111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h11111111, 16'd5, 16'd2};
    tbl[14] = '{32'h22222222, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h11111111, 16'd5, 16'd3};
    tbl[15] = '{32'h33333333, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333, 1'b1, 32'h11111111, 16'd6, 16'd3};
    tbl[16] = '{32'h44444444, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 1'b1, 32'h11111111, 16'd6, 16'd3};
    tbl[17] = '{32'h55555555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333, 1'b1, 32'h11111111, 16'd7, 16'd3};

    // Reset state, observed while rst_n is held low.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst out0_valid", {31'b0, out0_valid}, 32'h0);
    chk("rst out1_valid", {31'b0, out1_valid}, 32'h0);
    chk("rst out0_data", out0_data, 32'h0);
    chk("rst out1_data", out1_data, 32'h0);
    chk("rst cnt0", {16'b0, cnt0}, 32'h0);
    chk("rst cnt1", {16'b0, cnt1}, 32'h0);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out0_valid", i), {31'b0, out0_valid}, {31'b0, tbl[i].v0});
      chk($sformatf("vec%0d out0_data", i), out0_data, tbl[i].d0);
      chk($sformatf("vec%0d out1_valid", i), {31'b0, out1_valid}, {31'b0, tbl[i].v1});
      chk($sformatf("vec%0d out1_data", i), out1_data, tbl[i].d1);
      chk($sformatf("vec%0d cnt0", i), {16'b0, cnt0}, {16'b0, cexp(int'(tbl[i].c0))});
      chk($sformatf("vec%0d cnt1", i), {16'b0, cnt1}, {16'b0, cexp(int'(tbl[i].c1))});
    end

    // Both channels FULL: asynchronous reset between edges clears everything at once.
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out0_valid", {31'b0, out0_valid}, 32'h0);
    chk("midrst out1_valid", {31'b0, out1_valid}, 32'h0);
    chk("midrst out0_data", out0_data, 32'h0);
    chk("midrst out1_data", out1_data, 32'h0);
    chk("midrst cnt0", {16'b0, cnt0}, 32'h0);
    chk("midrst cnt1", {16'b0, cnt1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release accepts a word.
    drive(32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("post-rst in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("post-rst out0_valid", {31'b0, out0_valid}, 32'h1);
    chk("post-rst out0_data", out0_data, 32'hCAFEF00D);
    chk("post-rst out1_valid", {31'b0, out1_valid}, 32'h0);
    chk("post-rst cnt0", {16'b0, cnt0}, {16'b0, cexp(1)});

    do_reset();
    for (int i = 0; i < 2000; i++) rcycle();

    // Counter saturation on channel 1.
    do_reset();
    drive(32'h5A5A5A5A, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat cnt1 pre", {16'b0, cnt1}, {16'b0, cexp(65534)});
    repeat (3) @(posedge clk);
    #1;
    chk("sat cnt1", {16'b0, cnt1}, {16'b0, cexp(65535)});
    chk("sat cnt0", {16'b0, cnt0}, 32'h0);
    chk("sat out1_data", out1_data, 32'h5A5A5A5A);
    drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
